// File: rtl/wbc_pkg.sv
// rtl/wbc_pkg.sv - shared constants and FSM state type for the weight buffer controller
//
// Purpose: single source for the weight buffer geometry (entry count, index
// width, kernel word width) and the controller state encoding.
// Ports: none (package).

package wbc_pkg;

  localparam int WBC_DEPTH = 21;  // kernel entries in the weight buffer
  localparam int WBC_IDX_W = 7;   // width of index and count fields
  localparam int WBC_KW_W  = 72;  // width of one kernel word

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    FIN  = 2'd3
  } wbc_state_t;

endpackage

// File: rtl/weight_buf_ctrl.sv
// rtl/weight_buf_ctrl.sv - load/replay controller for the kernel weight buffer
//
// Purpose: loads N kernel words into an external weight buffer, then replays
// them P times to the PE array on a request/grant handshake.
// Optional feature macro: WBC_OVERLAP_EN - lets reads start during LOAD on
// the first pass, never overtaking the write pointer.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             one-cycle job launch (num_kernels/num_passes sampled)
//   num_kernels       kernels per job N (1..DEPTH)
//   num_passes        read sweeps P over the N kernels (>=1)
//   ld_valid/ld_ready upstream weight word handshake
//   wb_readen         buffer write enable (accepted word)
//   wb_in_index       buffer write index
//   wb_out_index      buffer read index
//   rd_req/rd_ack     PE array kernel request / combinational grant
//   rd_valid, rd_kidx buffer dataout valid one cycle after grant, its index
//   busy, done, err   not idle / job complete pulse / rejected start pulse

module weight_buf_ctrl
  import wbc_pkg::*;
#(
  parameter int DEPTH = WBC_DEPTH,
  parameter int IDX_W = WBC_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] num_kernels,
  input  logic [7:0]       num_passes,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             wb_readen,
  output logic [IDX_W-1:0] wb_in_index,
  output logic [IDX_W-1:0] wb_out_index,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_kidx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  wbc_state_t       state;
  wbc_state_t       state_nxt;
  logic [IDX_W-1:0] n_lat;
  logic [7:0]       p_lat;
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_cnt;
  logic [7:0]       pass_cnt;

  logic start_ok;
  logic wr_fire;
  logic wr_last;
  logic rd_last_k;
  logic rd_last;

  assign start_ok  = (num_kernels != '0) && (num_kernels <= DEPTH_I) &&
                     (num_passes != 8'd0);
  assign wr_fire   = ld_valid & ld_ready;
  assign wr_last   = wr_fire && (wr_cnt == n_lat - IDX_ONE);
  assign rd_last_k = (rd_cnt == n_lat - IDX_ONE);
  // Final grant of the job: last kernel of the last pass.
  assign rd_last   = rd_ack && rd_last_k && (pass_cnt == p_lat - 8'd1);

  assign wb_readen    = wr_fire;
  assign wb_in_index  = wr_cnt;
  assign wb_out_index = rd_cnt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && start_ok) state_nxt = LOAD;
      LOAD: if (wr_last)           state_nxt = READ;
      READ: if (rd_last)           state_nxt = FIN;
      FIN:                         state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ld_ready = (state == LOAD);
    busy     = (state != IDLE);
    done     = (state == FIN);   // FIN lasts one cycle, alongside the last rd_valid
    rd_ack   = 1'b0;
    unique case (state)
      READ: rd_ack = rd_req;
`ifdef WBC_OVERLAP_EN
      // Overlap is only possible on the first pass; a read may only
      // consume an entry that has already been written.
      LOAD: rd_ack = rd_req && (pass_cnt == 8'd0) && (rd_cnt < wr_cnt);
`endif
      default: rd_ack = 1'b0;
    endcase
  end

  // Job parameters, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_lat    <= '0;
      p_lat    <= 8'd0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      pass_cnt <= 8'd0;
      rd_valid <= 1'b0;
      rd_kidx  <= '0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ack;
      err      <= 1'b0;
      if (rd_ack) rd_kidx <= rd_cnt;

      if (state == IDLE) begin
        if (start) begin
          if (start_ok) begin
            n_lat    <= num_kernels;
            p_lat    <= num_passes;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            pass_cnt <= 8'd0;
          end else begin
            err <= 1'b1;
          end
        end
      end else begin
        if (wr_fire) wr_cnt <= wr_cnt + IDX_ONE;
        if (rd_ack) begin
          if (rd_last_k) begin
            rd_cnt   <= '0;
            pass_cnt <= pass_cnt + 8'd1;
          end else begin
            rd_cnt <= rd_cnt + IDX_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_buf_ctrl.sv
// tb/tb_weight_buf_ctrl.sv - directed self-checking bench for weight_buf_ctrl

module tb_weight_buf_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [6:0] num_kernels;
  logic [7:0] num_passes;
  logic       ld_valid;
  logic       ld_ready;
  logic       wb_readen;
  logic [6:0] wb_in_index;
  logic [6:0] wb_out_index;
  logic       rd_req;
  logic       rd_ack;
  logic       rd_valid;
  logic [6:0] rd_kidx;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  weight_buf_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_kernels  (num_kernels),
    .num_passes   (num_passes),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .wb_readen    (wb_readen),
    .wb_in_index  (wb_in_index),
    .wb_out_index (wb_out_index),
    .rd_req       (rd_req),
    .rd_ack       (rd_ack),
    .rd_valid     (rd_valid),
    .rd_kidx      (rd_kidx),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants;
    logic seen_done;

    rst = 1'b0; start = 1'b0; num_kernels = '0; num_passes = '0;
    ld_valid = 1'b0; rd_req = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_index", wb_in_index, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // N=3 P=2, back-to-back grants
    start = 1'b1; num_kernels = 7'd3; num_passes = 8'd2;
    #1 check("a_idle_busy", busy, 0);
    tick();
    start = 1'b0;
    check("a_load_busy", busy, 1);
    check("a_load_ready", ld_ready, 1);
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1;
      #1;
      check("a_wr_en", wb_readen, 1);
      check("a_wr_idx", wb_in_index, k);
      tick();
    end
    ld_valid = 1'b0;
    #1 check("a_read_no_ready", ld_ready, 0);
    rd_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("a_ack", rd_ack, 1);
      check("a_out_idx", wb_out_index, i % 3);
      tick();
      check("a_rd_valid", rd_valid, 1);
      check("a_kidx", rd_kidx, i % 3);
      check("a_done", done, (i == 5) ? 1 : 0);
    end
    #1 check("a_fin_no_ack", rd_ack, 0);
    rd_req = 1'b0;
    tick();
    check("a_idle_busy2", busy, 0);
    check("a_idle_done", done, 0);
    check("a_idle_valid", rd_valid, 0);

    // Rejected starts: N=0, N=22, P=0; rd_req in IDLE ignored
    rd_req = 1'b1;
    start = 1'b1; num_kernels = 7'd0; num_passes = 8'd1;
    #1 check("b_idle_no_ack", rd_ack, 0);
    tick();
    start = 1'b0;
    check("b_err_n0", err, 1);
    check("b_busy_n0", busy, 0);
    tick();
    check("b_err_clear", err, 0);
    start = 1'b1; num_kernels = 7'd22; num_passes = 8'd1;
    tick();
    start = 1'b0;
    check("b_err_n22", err, 1);
    check("b_busy_n22", busy, 0);
    start = 1'b1; num_kernels = 7'd3; num_passes = 8'd0;
    tick();
    start = 1'b0;
    check("b_err_p0", err, 1);
    check("b_busy_p0", busy, 0);
    rd_req = 1'b0;
    tick();

    // N=21 P=1, start ignored during LOAD, ld_valid every other cycle
    start = 1'b1; num_kernels = 7'd21; num_passes = 8'd1;
    tick();
    start = 1'b1; num_kernels = 7'd5; num_passes = 8'd3;
    tick();
    start = 1'b0;
    check("c_ign_busy", busy, 1);
    check("c_ign_ready", ld_ready, 1);
    check("c_ign_err", err, 0);
    check("c_ign_idx", wb_in_index, 0);
    for (int k = 0; k < 21; k++) begin
      ld_valid = 1'b1;
      #1;
      check("c_wr_en", wb_readen, 1);
      check("c_wr_idx", wb_in_index, k);
      tick();
      if (k < 20) begin
        ld_valid = 1'b0;
        #1;
        check("c_gap_en", wb_readen, 0);
        check("c_gap_ready", ld_ready, 1);
        tick();
      end
    end
    ld_valid = 1'b0;
    #1 check("c_read_entered", ld_ready, 0);
    rd_req = 1'b1;
    for (int i = 0; i < 21; i++) begin
      #1 check("c_out_idx", wb_out_index, i);
      tick();
      check("c_kidx", rd_kidx, i);
    end
    check("c_done", done, 1);
    rd_req = 1'b0;
    tick();
    check("c_idle", busy, 0);

    // Reset in the middle of pass 2, then a fresh N=1 P=1 job
    start = 1'b1; num_kernels = 7'd2; num_passes = 8'd3;
    tick();
    start = 1'b0;
    ld_valid = 1'b1;
    tick(); tick();
    ld_valid = 1'b0;
    rd_req = 1'b1;
    tick(); tick(); tick();
    check("d_pre_busy", busy, 1);
    check("d_pre_kidx", rd_kidx, 0);
    rst = 1'b0;
    #1;
    check("d_rst_busy", busy, 0);
    check("d_rst_ready", ld_ready, 0);
    check("d_rst_wren", wb_readen, 0);
    check("d_rst_ack", rd_ack, 0);
    check("d_rst_valid", rd_valid, 0);
    check("d_rst_kidx", rd_kidx, 0);
    check("d_rst_in_idx", wb_in_index, 0);
    check("d_rst_out_idx", wb_out_index, 0);
    check("d_rst_done", done, 0);
    check("d_rst_err", err, 0);
    rd_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start = 1'b1; num_kernels = 7'd1; num_passes = 8'd1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1;
    #1 check("d_new_wr_idx", wb_in_index, 0);
    tick();
    ld_valid = 1'b0;
    rd_req = 1'b1;
    #1 check("d_new_ack", rd_ack, 1);
    tick();
    rd_req = 1'b0;
    check("d_new_valid", rd_valid, 1);
    check("d_new_kidx", rd_kidx, 0);
    check("d_new_done", done, 1);
    tick();
    check("d_new_idle", busy, 0);

`ifdef WBC_OVERLAP_EN
    // Overlapped read during LOAD, N=4 P=1, rd_req held from start
    rd_req = 1'b1;
    start = 1'b1; num_kernels = 7'd4; num_passes = 8'd1;
    tick();
    start = 1'b0;
    ld_valid = 1'b1;
    #1 check("ov_stall_empty", rd_ack, 0);
    tick();
    ld_valid = 1'b0;
    #1;
    check("ov_first_grant", rd_ack, 1);
    check("ov_first_idx", wb_out_index, 0);
    grants = 1;
    tick();
    check("ov_stall_equal", rd_ack, 0);
    ld_valid = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      #1;
      if (rd_ack && ld_ready) check("ov_no_overtake", wb_out_index < wb_in_index, 1);
      if (rd_ack) grants++;
      if (done) seen_done = 1'b1;
      tick();
    end
    ld_valid = 1'b0;
    rd_req = 1'b0;
    check("ov_grants", grants, 4);
    check("ov_done", seen_done, 1);
    tick();
`else
    grants = 0;
    seen_done = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_buf_ctrl.md
WEIGHT_BUF_CTRL -- requirements
Module: weight_buf_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 21: number of 72-bit kernel entries in the attached weight buffer.
REQ-002 SHALL have parameter IDX_W, default 7: width of all buffer index and count fields.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle job launch pulse.
REQ-006 SHALL have port num_kernels, input, IDX_W bits: number of kernels N in the job; sampled on start.
REQ-007 SHALL have port num_passes, input, 8 bits: number of full read sweeps P over the N kernels; sampled on start.
REQ-008 SHALL have port ld_valid, input, 1 bit: upstream weight word valid.
REQ-009 SHALL have port ld_ready, output, 1 bit: the controller accepts a weight word.
REQ-010 SHALL have port wb_readen, output, 1 bit: buffer write enable, equal to ld_valid & ld_ready.
REQ-011 SHALL have port wb_in_index, output, IDX_W bits: buffer write index.
REQ-012 SHALL have port wb_out_index, output, IDX_W bits: buffer read index.
REQ-013 SHALL have port rd_req, input, 1 bit: PE array requests the next kernel.
REQ-014 SHALL have port rd_ack, output, 1 bit: combinational grant of rd_req in the current cycle.
REQ-015 SHALL have port rd_valid, output, 1 bit: buffer dataout holds the granted kernel, one cycle after rd_ack.
REQ-016 SHALL have port rd_kidx, output, IDX_W bits: kernel index qualified by rd_valid.
REQ-017 SHALL have port busy, output, 1 bit: the controller is not in IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse at job completion.
REQ-019 SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, READ and FIN.
REQ-021 SHALL, in IDLE, move to LOAD on start when 1<=N<=DEPTH and P>=1, latching N and P and clearing wr_cnt, rd_cnt and pass_cnt.
REQ-022 SHALL, in IDLE, pulse err and remain in IDLE on start with N=0, N>DEPTH or P=0.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL hold ld_ready=1 in LOAD only and drive wb_in_index=wr_cnt; each accepted word increments wr_cnt.
REQ-025 SHALL move from LOAD to READ on the edge where wr_cnt reaches N.
REQ-026 SHALL, in READ, drive wb_out_index=rd_cnt combinationally and set rd_ack=rd_req.
REQ-027 SHALL, on rd_ack, register rd_valid=1 and rd_kidx=rd_cnt for the next cycle, then advance rd_cnt.
REQ-028 SHALL wrap rd_cnt from N-1 to 0 and increment pass_cnt at the wrap; after the last grant of pass P it SHALL enter FIN.
REQ-029 SHALL, in FIN, pulse done for one cycle (aligned with the final rd_valid) and return to IDLE.
REQ-030 SHALL deassert wb_readen, ld_ready and rd_ack when not in their respective states; rd_req in IDLE, LOAD or FIN SHALL be ignored.
REQ-031 SHALL support back-to-back grants (rd_req held high gives one kernel per cycle) and arbitrary gaps on both handshakes.

Reset
REQ-032 SHALL, on rst low, immediately force IDLE, clear all counters, and drive ld_ready, wb_readen, rd_ack, rd_valid, busy, done and err to 0, and wb_in_index, wb_out_index and rd_kidx to 0.
REQ-033 SHALL abandon any job in progress on reset; buffer contents SHALL be treated as invalid afterwards.

Configuration
REQ-034 SHALL, with WBC_OVERLAP_EN defined, also grant rd_req during LOAD when rd_cnt < wr_cnt (first pass only), and SHALL stall grants when rd_cnt = wr_cnt.
REQ-035 SHALL, without WBC_OVERLAP_EN, grant reads only in READ.

Structure
REQ-036 SHALL take the FSM state enum, DEPTH, IDX_W and the 72-bit kernel word width from the shared package wbc_pkg.
REQ-037 SHALL be a single module with no sub-module; the weight buffer itself is instantiated by the parent.

Verification
REQ-038 SHALL pass: start N=3 P=2, three words then rd_req held high -> wb_in_index 0,1,2; rd_kidx 0,1,2,0,1,2 on consecutive cycles; done with the last rd_valid.
REQ-039 SHALL pass: start with N=0, then with N=22 -> err pulses each time, busy stays 0.
REQ-040 SHALL pass: N=21 P=1 with ld_valid toggled every other cycle -> 21 writes to indices 0..20, READ entered after the 21st.
REQ-041 SHALL pass: rst low mid-READ of pass 2 -> all outputs 0 the same cycle; a new start N=1 P=1 completes normally.
REQ-042 SHALL pass: WBC_OVERLAP_EN, N=4, rd_req held from the start -> first rd_ack the cycle after the write to index 0, no grant ahead of wr_cnt.
REQ-043 SHALL pass: start pulsed during LOAD -> ignored, latched N and P unchanged.
